// File: rtl/rr_arbiter_8_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_8_if
//  Description : Request/grant bundle between eight requesters and the
//                round-robin arbiter. The master side is the requester pool.
//                The slave side is the arbiter that owns the select bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_arbiter_8_if;
  logic [7:0] req;        // level-sensitive request vector, bit i = requester i
  logic       done;       // single-cycle release pulse from the current owner
  logic [7:0] gnt;        // registered one-hot grant
  logic [2:0] gnt_idx;    // index of the granted requester
  logic       gnt_valid;  // a grant is active
  logic       timeout;    // one-cycle pulse on a forced release

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_8
//  Description : Eight-way round-robin arbiter with registered one-hot grant.
//                A grant is held until the owner pulses done or drops its
//                request. Exactly one all-zero cycle separates two grants.
//                Optional forced release after TIMEOUT_CYC cycles is compiled
//                in with the macro RR_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_8 #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  wire logic      clk,
  input  wire logic      rst,
  rr_arbiter_8_if.slave  bus
);

  // Stop elaboration on an out-of-range hold limit.
  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
    $error("rr_arbiter_8: TIMEOUT_CYC must be in 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic [2:0] r_gnt_idx, w_gnt_idx_nxt;
  logic [7:0] r_gnt, w_gnt_nxt;
  logic       r_gnt_valid, w_gnt_valid_nxt;
  logic       r_timeout, w_timeout_nxt;

  logic       w_found;
  logic [2:0] w_winner;
  logic       w_to_hit;
  logic       w_release;

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt, w_hold_cnt_nxt;

  // Forced release fires on the edge that ends the TIMEOUT_CYC-th grant cycle.
  always_comb begin
    w_to_hit = (r_state == ST_GRANT) && (r_hold_cnt == 8'(TIMEOUT_CYC - 1));
  end
`else
  // No hold limit: a grant lasts until done or an owner request drop.
  always_comb begin
    w_to_hit = 1'b0;
  end
`endif

  // Priority search starting just after the last granted index, wrapping 7 -> 0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int k = 1; k <= 8; k++) begin
      if (!w_found && bus.req[r_ptr + 3'(k)]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + 3'(k);
      end
    end
  end

  // Next-state and next-output logic; no preemption, release forces one idle cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_nxt       = r_gnt;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;
    w_release       = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    w_hold_cnt_nxt  = r_hold_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt     = ST_GRANT;
          w_gnt_idx_nxt   = w_winner;
          w_gnt_valid_nxt = 1'b1;
          w_gnt_nxt       = 8'b1 << w_winner;
`ifdef RR_ARB_TIMEOUT_EN
          w_hold_cnt_nxt  = 8'd0;
`endif
        end
      end
      ST_GRANT: begin
        // done, owner drop and timeout may coincide; all collapse to one release.
        w_release = bus.done || !bus.req[r_gnt_idx] || w_to_hit;
`ifdef RR_ARB_TIMEOUT_EN
        w_hold_cnt_nxt = r_hold_cnt + 8'd1;
`endif
        if (w_release) begin
          w_state_nxt     = ST_IDLE;
          w_ptr_nxt       = r_gnt_idx;
          w_gnt_valid_nxt = 1'b0;
          w_gnt_nxt       = 8'b0;
          w_timeout_nxt   = w_to_hit;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_gnt_valid_nxt = 1'b0;
        w_gnt_nxt       = 8'b0;
      end
    endcase
  end

  // State and output registers; reset discards any grant without bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 3'd7;
      r_gnt_idx   <= 3'd0;
      r_gnt       <= 8'b0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  // Hold counter: cleared on grant, counts every cycle a grant is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= 8'd0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end
`endif

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_8
//  Description : Scoreboard bench for rr_arbiter_8. Stimulus pushes expected
//                outputs from a behavioural model; a monitor pops and compares.
//                Honors RR_ARB_TIMEOUT_EN in its model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_8;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: owner is -1 while no grant is held.
  int m_owner = -1;
  int m_ptr   = 7;
  int m_idx   = 0;
  int m_cnt   = 0;

  // Drive one cycle of inputs, advance the model across the next rising edge,
  // and queue the outputs expected after that edge.
  task automatic step(input bit r, input logic [7:0] rq, input bit d);
    exp_t e;
    bit   rel;
    bit   to;
    @(negedge clk);
    rst      = r;
    bus.req  = rq;
    bus.done = d;
    to = 1'b0;
    if (r) begin
      m_owner = -1;
      m_ptr   = 7;
      m_idx   = 0;
      m_cnt   = 0;
    end else if (m_owner >= 0) begin
      rel = d || !rq[m_owner];
`ifdef RR_ARB_TIMEOUT_EN
      if (m_cnt == TIMEOUT_CYC - 1) begin
        rel = 1'b1;
        to  = 1'b1;
      end
`endif
      m_cnt++;
      if (rel) begin
        m_ptr   = m_owner;
        m_owner = -1;
      end
    end else if (rq != 8'h00) begin
      for (int k = 1; k <= 8; k++) begin
        if (m_owner < 0 && rq[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
        end
      end
      m_idx = m_owner;
      m_cnt = 0;
    end
    e.gnt   = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    e.idx   = 3'(m_idx);
    e.valid = (m_owner >= 0);
    e.to    = to;
    q.push_back(e);
  endtask

  // Monitor: the arbiter presents its outputs every cycle; check each one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_cmp++;
        if (bus.gnt !== e.gnt || bus.gnt_idx !== e.idx ||
            bus.gnt_valid !== e.valid || bus.timeout !== e.to) begin
          n_err++;
          $display("FAIL scoreboard t=%0t actual gnt=%h idx=%0d valid=%b to=%b required gnt=%h idx=%0d valid=%b to=%b",
                   $time, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout,
                   e.gnt, e.idx, e.valid, e.to);
        end
      end
    end
  end

  initial begin
    logic [7:0] rq;
    bus.req  = 8'h00;
    bus.done = 1'b0;

    // Reset held with all requesters active, then first grant goes to idx 0.
    repeat (3) step(1'b1, 8'hFF, 1'b0);
    // Full rotation: done on each grant's first cycle.
    repeat (18) step(1'b0, 8'hFF, m_owner >= 0);

    // Sparse wrap from ptr=7: 1, 7, 1.
    step(1'b1, 8'h00, 1'b0);
    repeat (7) step(1'b0, 8'h82, m_owner >= 0);

    // Owner drop with a new request arriving mid-grant (no preemption).
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h08, 1'b0);
    repeat (3) step(1'b0, 8'h09, 1'b0);
    repeat (3) step(1'b0, 8'h01, 1'b0);

    // Reset mid-grant, then requester 0 must have first priority again.
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h10, 1'b0);
    repeat (2) step(1'b0, 8'h10, 1'b0);
    step(1'b1, 8'h10, 1'b0);
    step(1'b0, 8'hFF, 1'b0);
    step(1'b0, 8'hFF, 1'b1);

    // Long hold with no done: indefinite grant, or periodic timeout if built in.
    repeat (120) step(1'b0, 8'h20, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Randomised traffic with occasional reset.
    repeat (600) begin
      rq = 8'($urandom) & 8'($urandom);
      step(($urandom_range(0, 63) == 0), rq, ($urandom_range(0, 3) == 0));
    end
    step(1'b0, 8'h00, 1'b0);

    repeat (2) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain actual %0d pending required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
